stage_decode_q: RTL

STAGE_DECODE_Q -- requirements
Module: stage_decode_q

---
 rtl/stage_decode_q.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/stage_decode_q.sv
// Decode-stage instruction queue with field decode and an integrated register file.
// The head entry is decoded combinationally, and its operands can be forwarded from writeback.
module stage_decode_q #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int NREG  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,

    input  logic                       inValid,
    output logic                       inReady,
    input  logic [31:0]                instrF,
    input  logic [XLEN-1:0]            pcF,
    input  logic [XLEN-1:0]            pcPlus4F,
    input  logic                       bPredictedTakenF,

    output logic                       outValid,
    input  logic                       outReady,
    output logic [4:0]                 rdAddr,
    output logic [4:0]                 r1Addr,
    output logic [4:0]                 r2Addr,
    output logic [4:0]                 op,
    output logic [2:0]                 funct3,
    output logic                       funct7_6,
    output logic [24:0]                immSrc,
    output logic [XLEN-1:0]            pc,
    output logic [XLEN-1:0]            pcPlus4,
    output logic                       bPredictedTaken,
    output logic [XLEN-1:0]            r1,
    output logic [XLEN-1:0]            r2,

    input  logic                       regWriteW,
    input  logic [4:0]                 rdAddrW,
    input  logic [XLEN-1:0]            rdW,

    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int RAW = $clog2(NREG);

    // Queue payload storage.
    logic [31:0]       r_q_instr [DEPTH];
    logic [XLEN-1:0]   r_q_pc    [DEPTH];
    logic [XLEN-1:0]   r_q_pc4   [DEPTH];
    logic              r_q_bpt   [DEPTH];

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic [XLEN-1:0]   r_regs    [NREG];

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic [31:0]       w_head_instr;
    logic [XLEN-1:0]   w_r1_rf;
    logic [XLEN-1:0]   w_r2_rf;
    logic              w_wr_en;

    // Handshake. The full check ignores outReady, so a full queue never
    // takes a new packet in the same cycle that it drains one.
    assign w_full   = (r_count == CW'(DEPTH));
    assign inReady  = !w_full;
    assign outValid = (r_count != '0);
    assign count    = r_count;

    assign w_push   = inValid  & inReady  & !flush;
    assign w_pop    = outValid & outReady & !flush;

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, whatever order the processes run in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the payload array has no reset. Every output it feeds is gated
    // by outValid, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= instrF;
            r_q_pc[r_wr_ptr]    <= pcF;
            r_q_pc4[r_wr_ptr]   <= pcPlus4F;
            r_q_bpt[r_wr_ptr]   <= bPredictedTakenF;
        end
    end

    // An empty queue presents an all-zero bubble.
    assign w_head_instr    = outValid ? r_q_instr[r_rd_ptr] : 32'd0;
    assign pc              = outValid ? r_q_pc[r_rd_ptr]    : '0;
    assign pcPlus4         = outValid ? r_q_pc4[r_rd_ptr]   : '0;
    assign bPredictedTaken = outValid ? r_q_bpt[r_rd_ptr]   : 1'b0;

    assign rdAddr   = w_head_instr[11:7];
    assign r1Addr   = w_head_instr[19:15];
    assign r2Addr   = w_head_instr[24:20];
    assign op       = w_head_instr[6:2];
    assign funct3   = w_head_instr[14:12];
    assign funct7_6 = w_head_instr[30];
    assign immSrc   = w_head_instr[31:7];

    // Register file. Writes do not depend on flush, stall or queue state.
    assign w_wr_en = regWriteW && (rdAddrW != 5'd0) && (32'(rdAddrW) < NREG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rdAddrW[RAW-1:0]] <= rdW;
        end
    end

    assign w_r1_rf = (32'(r1Addr) < NREG) ? r_regs[r1Addr[RAW-1:0]] : '0;
    assign w_r2_rf = (32'(r2Addr) < NREG) ? r_regs[r2Addr[RAW-1:0]] : '0;

    // NOTE: every branch assigns the operand, so no latch is inferred.
    // The writeback value is forwarded ahead of the array read.
    always_comb begin
        if (r1Addr == 5'd0) begin
            r1 = '0;
        end else if (w_wr_en && (rdAddrW == r1Addr)) begin
            r1 = rdW;
        end else begin
            r1 = w_r1_rf;
        end

        if (r2Addr == 5'd0) begin
            r2 = '0;
        end else if (w_wr_en && (rdAddrW == r2Addr)) begin
            r2 = rdW;
        end else begin
            r2 = w_r2_rf;
        end
    end

    // The low opcode bits are always 2'b11 and carry no decode information.
    logic w_unused;
    assign w_unused = &{1'b0, w_head_instr[1:0]};

endmodule
